pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Sequencing controller for the three-stage core: F (fetch), X (execute datapath), W (memory/writeback).
- Generates the PC write enable, the PC redirect select, and the enable/kill for the F->X and X->W pipeline registers.
- Resolves, in priority order, cache stalls, taken jumps from X and load-use interlocks.
- Keeps wrap-around performance counters for cycles, retired instructions, stalls and flushes.

Parameters:
- FLUSH_CYCLES, 1, cycles of wrong-path kill after a redirect (icache latency); legal range 1..3.
- BOOT_CYCLES, 4, cycles PC is held after reset deassertion before fetch starts; legal range 1..15.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- icache_stall  in  1  fetch result not valid this cycle.
- dcache_stall  in  1  load/store in W not complete this cycle.
- x_valid  in  1  X holds a real (non-bubble) instruction.
- x_jump  in  1  jump taken, from the execute datapath.
- x_rs1, x_rs2  in  5 each  source registers of the instruction in X.
- x_uses_rs1, x_uses_rs2  in  1 each  X instruction reads that source.
- w_valid, w_is_load, w_reg_we  in  1 each  attributes of the instruction in W.
- w_rd  in  5  destination register of the instruction in W.
- pc_we  out  1  PC register update enable.
- pc_sel_jump  out  1  PC next = jump target (1) or PC+4 (0).
- fx_we, fx_kill  out  1 each  F->X register enable; kill loads a NOP/bubble.
- xw_we, xw_kill  out  1 each  X->W register enable; kill loads a bubble.
- cyc_cnt, ret_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- State register values: BOOT, RUN, FLUSH, WAIT. The state register is reset asynchronously to BOOT. The boot counter and flush counter are reset to 0. All four performance counters are reset to 0.
- While reset=0, outputs are: pc_we=0, pc_sel_jump=0, fx_we=0, xw_we=0, fx_kill=1, xw_kill=1.
- Outputs are combinational from the state and the current inputs. A stall takes effect in the same cycle.
- Hazard terms, evaluated every cycle:
  - mem_stall = icache_stall | dcache_stall.
  - lu = w_valid & w_is_load & w_reg_we & (w_rd != 0) & ((x_uses_rs1 & x_rs1 == w_rd) | (x_uses_rs2 & x_rs2 == w_rd)).
  - jmp = x_valid & x_jump.
- BOOT:
  - All enables 0; fx_kill=1; xw_kill=1.
  - Counts BOOT_CYCLES cycles, then moves to RUN.
  - mem_stall is ignored.
- RUN, resolved in priority order:
  - mem_stall: every enable is 0; kills are 0 (everything holds). Next state WAIT.
  - jmp: pc_we=1, pc_sel_jump=1, fx_we=1, fx_kill=1, xw_we=1. The jump retires. Next state FLUSH if FLUSH_CYCLES>1, otherwise RUN. lu is ignored because the dependent instruction is killed.
  - lu: pc_we=0, fx_we=0 (X holds), xw_we=1, xw_kill=1 (bubble into W). Stays in RUN, so one bubble per load-use.
  - Otherwise: all enables are 1 and both kills are 0.
- FLUSH:
  - pc_we=1, fx_we=1, fx_kill=1, xw_we=1.
  - Stays for FLUSH_CYCLES-1 cycles, then returns to RUN.
  - A mem_stall freezes the flush counter and holds all enables at 0.
  - x_jump is ignored while in FLUSH.
- WAIT:
  - Everything holds.
  - Returns to RUN on the first cycle with mem_stall=0. That cycle is evaluated as RUN, with no extra bubble.
  - A pending flush, entered from FLUSH, resumes FLUSH instead.
- Counters (each wraps modulo 2^CNT_W with no saturation; none counts in BOOT):
  - cyc_cnt: +1 every cycle outside BOOT.
  - ret_cnt: +1 when xw_we & !xw_kill & x_valid.
  - stall_cnt: +1 on each cycle with a mem_stall hold or an lu bubble.
  - flush_cnt: +1 on each cycle with fx_kill=1 outside BOOT.
- Asserting reset mid-operation (WAIT, FLUSH or a stall) returns immediately to BOOT with the reset output values.

Test Plan:
- Reset release with BOOT_CYCLES=4 -> pc_we=0 and fx_kill=1 for exactly 4 cycles; pc_we=1 on cycle 5; cyc_cnt=1 after the first RUN edge.
- Load in W with w_rd=5 and X reading x_rs2=5 -> one cycle with fx_we=0, xw_kill=1, pc_we=0; stall_cnt+1; the next cycle has normal enables. Repeat with w_rd=0 -> no stall.
- x_jump=1 with x_valid=1 and FLUSH_CYCLES=2 -> pc_sel_jump=1 for one cycle, then fx_kill=1 for 2 consecutive cycles; flush_cnt+2; ret_cnt+1.
- dcache_stall held 3 cycles during a load-use condition -> 3 cycles with all enables 0; then the lu bubble; stall_cnt+4.
- x_jump and lu in the same cycle -> jump response only; no lu bubble in that cycle.
- Preload counters to 2^32-1 via forced state, then one retire -> ret_cnt wraps to 0; reset mid-WAIT -> BOOT with outputs at reset values immediately.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//
// Sequencing controller for a three-stage core: F (fetch), X (execute) and
// W (memory/writeback). Every cycle it decides whether the PC advances or
// redirects, and whether the F->X and X->W registers load, hold or take a
// bubble. Cache stalls win over taken jumps, and jumps win over load-use
// interlocks. Four wrap-around performance counters are kept as well.
//
// Ports
//   clk                     core clock, rising edge
//   reset                   asynchronous active-low reset (0 = in reset)
//   icache_stall            fetch result not valid this cycle
//   dcache_stall            load/store in W not complete this cycle
//   x_valid, x_jump         X holds a real instruction / taken jump from X
//   x_rs1, x_rs2            source registers of the X instruction
//   x_uses_rs1, x_uses_rs2  X instruction reads that source
//   w_valid, w_is_load,
//   w_reg_we, w_rd          attributes of the instruction in W
//   pc_we, pc_sel_jump      PC update enable / next PC = jump target
//   fx_we, fx_kill          F->X register enable / load a bubble
//   xw_we, xw_kill          X->W register enable / load a bubble
//   cyc_cnt, ret_cnt,
//   stall_cnt, flush_cnt    performance counters (wrap modulo 2^CNT_W)
//   state_dbg               current controller state (0 BOOT, 1 RUN,
//                           2 FLUSH, 3 WAIT)
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // 1..3
    parameter int BOOT_CYCLES  = 4,   // 1..15
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             x_valid,
    input  logic             x_jump,
    input  logic [4:0]       x_rs1,
    input  logic [4:0]       x_rs2,
    input  logic             x_uses_rs1,
    input  logic             x_uses_rs2,
    input  logic             w_valid,
    input  logic             w_is_load,
    input  logic             w_reg_we,
    input  logic [4:0]       w_rd,
    output logic             pc_we,
    output logic             pc_sel_jump,
    output logic             fx_we,
    output logic             fx_kill,
    output logic             xw_we,
    output logic             xw_kill,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    // Index of the last FLUSH cycle; only meaningful when FLUSH is reachable.
    localparam logic [1:0] FLUSH_LAST = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    state_t           eff_state;
    logic [3:0]       boot_pos_q, boot_pos_d;
    logic [1:0]       flush_pos_q, flush_pos_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic lu;
    logic jmp;
    logic hold;      // cycle frozen by a cache stall
    logic bubble;    // cycle spent on a load-use bubble

    always_comb begin
        mem_stall = icache_stall | dcache_stall;
        lu = w_valid & w_is_load & w_reg_we & (w_rd != 5'd0) &
             ((x_uses_rs1 & (x_rs1 == w_rd)) | (x_uses_rs2 & (x_rs2 == w_rd)));
        jmp = x_valid & x_jump;

        // The first stall-free cycle in WAIT behaves exactly like the state
        // we came from (RUN, or FLUSH with a flush still pending), so the
        // release costs no extra cycle.
        eff_state = state_q;
        if (state_q == ST_WAIT && !mem_stall) begin
            eff_state = flush_pend_q ? ST_FLUSH : ST_RUN;
        end

        pc_we        = 1'b0;
        pc_sel_jump  = 1'b0;
        fx_we        = 1'b0;
        fx_kill      = 1'b0;
        xw_we        = 1'b0;
        xw_kill      = 1'b0;
        hold         = 1'b0;
        bubble       = 1'b0;
        state_d      = state_q;
        boot_pos_d   = boot_pos_q;
        flush_pos_d  = flush_pos_q;
        flush_pend_d = flush_pend_q;

        case (eff_state)
            ST_BOOT: begin
                // Reset also lands here asynchronously, so these are the
                // in-reset output values too. Cache stalls are ignored.
                fx_kill = 1'b1;
                xw_kill = 1'b1;
                if (boot_pos_q == BOOT_LAST) begin
                    boot_pos_d = 4'd0;
                    state_d    = ST_RUN;
                end else begin
                    boot_pos_d = boot_pos_q + 4'd1;
                end
            end

            ST_RUN: begin
                if (mem_stall) begin
                    hold         = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = ST_WAIT;
                end else if (jmp) begin
                    // The instruction behind the jump is killed, so a
                    // simultaneous load-use does not matter.
                    pc_we       = 1'b1;
                    pc_sel_jump = 1'b1;
                    fx_we       = 1'b1;
                    fx_kill     = 1'b1;
                    xw_we       = 1'b1;
                    flush_pos_d = 2'd0;
                    state_d     = HAS_FLUSH ? ST_FLUSH : ST_RUN;
                end else if (lu) begin
                    // X holds, a bubble goes to W; next cycle the load has
                    // left W so only one bubble is inserted.
                    xw_we   = 1'b1;
                    xw_kill = 1'b1;
                    bubble  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    pc_we   = 1'b1;
                    fx_we   = 1'b1;
                    xw_we   = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (mem_stall) begin
                    // Freeze the flush position and resume it after WAIT.
                    hold         = 1'b1;
                    flush_pend_d = 1'b1;
                    state_d      = ST_WAIT;
                end else begin
                    pc_we        = 1'b1;
                    fx_we        = 1'b1;
                    fx_kill      = 1'b1;
                    xw_we        = 1'b1;
                    flush_pend_d = 1'b0;
                    if (flush_pos_q == FLUSH_LAST) begin
                        flush_pos_d = 2'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_pos_d = flush_pos_q + 2'd1;
                        state_d     = ST_FLUSH;
                    end
                end
            end

            ST_WAIT: begin
                // Only reached while the stall is still present.
                hold    = 1'b1;
                state_d = ST_WAIT;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        cyc_cnt_d   = cyc_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ST_BOOT) begin
            cyc_cnt_d = cyc_cnt_q + CNT_ONE;
            if (xw_we && !xw_kill && x_valid) begin
                ret_cnt_d = ret_cnt_q + CNT_ONE;
            end
            if (hold || bubble) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (fx_kill) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_BOOT;
            boot_pos_q   <= 4'd0;
            flush_pos_q  <= 2'd0;
            flush_pend_q <= 1'b0;
            cyc_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            boot_pos_q   <= boot_pos_d;
            flush_pos_q  <= flush_pos_d;
            flush_pend_q <= flush_pend_d;
            cyc_cnt_q    <= cyc_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign ret_cnt   = ret_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_dbg = state_q;

endmodule
